// File: rtl/case_dec_arbiter_if.sv
// Handshake bundle between operand producers, the shared decoder and the result consumer.
// Ports: req/val1_i/val2_i/rsp_ready flow into the decoder; gnt/rsp_*/miss_count flow out.
// master = requester/consumer side, slave = decoder side.
interface case_dec_arbiter_if #(
    parameter int NREQ = 2,
    parameter int CNTW = 8
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] val1_i;
    logic [3*NREQ-1:0] val2_i;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [2:0]        rsp_result;
    logic              rsp_hit;
    logic [CNTW-1:0]   miss_count;

    modport master (
        output req, val1_i, val2_i, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_result, rsp_hit, miss_count
    );

    modport slave (
        input  req, val1_i, val2_i, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_result, rsp_hit, miss_count
    );
endinterface

// File: rtl/case_dec_arbiter.sv
// Round-robin shared masked-case decoder: grants one requester, decodes val1&val2, returns result.
// Latency: capture edge E0, gnt pulse in the following cycle, rsp_valid from E1; 3 cycles minimum.
// Backpressure: rsp_ready low holds the response (fields frozen) and blocks all new arbitration.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries req, val1_i/val2_i packed
// 3 bits per requester, gnt one-hot pulse, rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_hit response,
// and miss_count, a saturating count of decodes that hit no case label.
module case_dec_arbiter #(
    parameter int NREQ = 2,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    case_dec_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // arbitration
    logic [2:0]        ptr;
    logic [2*NREQ-1:0] req_dbl;
    logic [2:0]        win_off;
    logic [3:0]        win_sum;
    logic [2:0]        win_idx;
    logic [2:0]        ptr_nxt;
    logic              any_req;
    logic [2:0]        sel_v1;
    logic [2:0]        sel_v2;

    // latched transaction
    logic [2:0]        lat_v1;
    logic [2:0]        lat_v2;
    logic [2:0]        lat_id;
    logic [2:0]        masked;

    // registered outputs
    logic [NREQ-1:0]   gnt_q;
    logic              rsp_valid_q;
    logic [2:0]        rsp_id_q;
    logic [2:0]        res_q;
    logic              hit_q;
    logic [CNTW-1:0]   miss_q;

    assign any_req = |bus.req;

    // Rotate req so that bit 0 corresponds to requester ptr; the lowest set bit of the
    // rotated vector is then the round-robin winner's distance from ptr.
    assign req_dbl = {bus.req, bus.req} >> ptr;

    always_comb begin
        win_off = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_dbl[k]) begin
                win_off = 3'(k);
            end
        end
    end

    assign win_sum = {1'b0, ptr} + {1'b0, win_off};
    assign win_idx = (win_sum >= 4'(NREQ)) ? 3'(win_sum - 4'(NREQ)) : win_sum[2:0];
    assign ptr_nxt = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;

    // Operand mux for the winner, built from constant slices.
    always_comb begin
        sel_v1 = 3'd0;
        sel_v2 = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                sel_v1 = bus.val1_i[3*i +: 3];
                sel_v2 = bus.val2_i[3*i +: 3];
            end
        end
    end

    assign masked = lat_v1 & lat_v2;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = DECODE;
            DECODE:  state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, decode in DECODE, hold in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= 3'd0;
            lat_v1      <= 3'd0;
            lat_v2      <= 3'd0;
            lat_id      <= 3'd0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 3'd0;
            res_q       <= 3'd0;
            hit_q       <= 1'b0;
            miss_q      <= '0;
        end else begin
            // gnt is a single-cycle pulse covering the DECODE cycle only
            gnt_q <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q  <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        lat_v1 <= sel_v1;
                        lat_v2 <= sel_v2;
                        lat_id <= win_idx;
                        ptr    <= ptr_nxt;
                    end
                end
                DECODE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= lat_id;
                    // Unmatched codes are no-action: res_q keeps whatever the last hit wrote,
                    // regardless of which requester produced it.
                    case (masked)
                        3'b000: begin res_q <= 3'd0; hit_q <= 1'b1; end
                        3'b001: begin res_q <= 3'd1; hit_q <= 1'b1; end
                        3'b010: begin res_q <= 3'd2; hit_q <= 1'b1; end
                        default: begin
                            hit_q <= 1'b0;
                            if (miss_q != {CNTW{1'b1}}) begin
                                miss_q <= miss_q + 1'b1;
                            end
                        end
                    endcase
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_hit    = hit_q;
    assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_case_dec_arbiter.sv
// Self-checking bench for case_dec_arbiter: directed sequences plus randomized transactions
// compared against a transaction-level reference (round-robin pick, held result, saturating misses).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_case_dec_arbiter;
    localparam int NREQ = 2;
    localparam int CNTW = 8;
    localparam int MISS_MAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    case_dec_arbiter_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();

    case_dec_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference state
    int m_ptr  = 0;
    int m_res  = 0;
    int m_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_rsp(input int w, input int exp_hit);
        check_val("rsp_valid", bus.rsp_valid, 1);
        check_val("rsp_id", bus.rsp_id, w);
        check_val("rsp_result", bus.rsp_result, m_res);
        check_val("rsp_hit", bus.rsp_hit, exp_hit);
        check_val("miss_count", bus.miss_count, m_miss);
    endtask

    // Called at a falling edge; returns at a falling edge with the DUT back in idle.
    task automatic run_txn(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] v1,
                           input logic [3*NREQ-1:0] v2, input int stall);
        int w;
        int mk;
        int exp_hit;
        bus.req       = r;
        bus.val1_i    = v1;
        bus.val2_i    = v2;
        bus.rsp_ready = (stall == 0);
        w  = rr_pick(r);
        mk = int'(v1[3*w +: 3] & v2[3*w +: 3]);
        if (mk <= 2) begin
            m_res   = mk;
            exp_hit = 1;
        end else begin
            exp_hit = 0;
            if (m_miss < MISS_MAX) m_miss++;
        end
        m_ptr = (w + 1) % NREQ;

        @(negedge clk);
        check_val("gnt", bus.gnt, 1 << w);
        check_val("valid_early", bus.rsp_valid, 0);
        // operand/req changes after capture must not matter
        bus.req    = NREQ'($urandom);
        bus.val1_i = (3*NREQ)'($urandom);
        bus.val2_i = (3*NREQ)'($urandom);

        @(negedge clk);
        check_val("gnt_off", bus.gnt, 0);
        check_rsp(w, exp_hit);

        for (int s = 0; s < stall; s++) begin
            bus.req = NREQ'($urandom);
            @(negedge clk);
            check_val("stall_gnt", bus.gnt, 0);
            check_rsp(w, exp_hit);
        end
        bus.rsp_ready = 1'b1;
        if (stall != 0) @(negedge clk);
        else @(negedge clk);
        check_val("released", bus.rsp_valid, 0);
        check_val("idle_gnt", bus.gnt, 0);
        bus.req = '0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_gnt"}, bus.gnt, 0);
        check_val({tag, "_valid"}, bus.rsp_valid, 0);
        check_val({tag, "_id"}, bus.rsp_id, 0);
        check_val({tag, "_result"}, bus.rsp_result, 0);
        check_val({tag, "_hit"}, bus.rsp_hit, 0);
        check_val({tag, "_miss"}, bus.miss_count, 0);
    endtask

    initial begin
        logic [NREQ-1:0] r;
        bus.req       = '0;
        bus.val1_i    = '0;
        bus.val2_i    = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed decode sequence
        run_txn(2'b01, 6'b000_000, 6'b000_000, 0);   // 000 -> 0 hit
        run_txn(2'b10, 6'b001_000, 6'b011_000, 0);   // 001 -> 1 hit
        run_txn(2'b01, 6'b000_111, 6'b000_011, 0);   // 011 miss, held 1
        run_txn(2'b01, 6'b000_110, 6'b000_110, 0);   // 110 miss, held 1
        run_txn(2'b01, 6'b000_010, 6'b000_010, 0);   // 010 -> 2 hit
        // backpressure: 5 stalled cycles
        run_txn(2'b10, 6'b001_000, 6'b111_000, 5);
        // both requesting continuously: alternate 0,1,0,1
        for (int i = 0; i < 4; i++) run_txn(2'b11, 6'b001_001, 6'b011_001, 0);
        // saturate the miss counter
        for (int i = 0; i < 300; i++) run_txn(2'b01, 6'b000_111, 6'b000_111, 0);
        check_val("miss_sat", bus.miss_count, MISS_MAX);
        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(r, (3*NREQ)'($urandom), (3*NREQ)'($urandom), $urandom_range(0, 3));
        end

        // asynchronous reset while a response is pending
        bus.req       = 2'b01;
        bus.val1_i    = 6'b000_001;
        bus.val2_i    = 6'b000_001;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        check_val("pre_reset_valid", bus.rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        m_ptr  = 0;
        m_res  = 0;
        m_miss = 0;
        @(negedge clk);
        check_zero("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(2'b11, 6'b111_111, 6'b111_111, 0);   // fresh ptr -> requester 0, miss
        run_txn(2'b11, 6'b010_000, 6'b011_000, 1);   // requester 1, 010 -> 2

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/case_dec_arbiter.md
# case_dec_arbiter

Shares one masked-case decode resource between NREQ requesters and sequences each decode transaction. Each requester presents two 3-bit operands; the block arbitrates round-robin, latches the winner's operands, decodes `val1 & val2` through a case with no default (unmatched codes leave the previous result unchanged), and returns the result over a valid/ready response channel. It sits between operand-producing stimulus blocks and any consumer of the decoded result, and counts no-action decodes.

## Interface
- NREQ, 2, number of requesters (2..8)
- CNTW, 8, width of miss counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request, level
- val1_i  in  3*NREQ  operand 1, requester i at bits [3i+2:3i]
- val2_i  in  3*NREQ  operand 2, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were captured
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  3  index of requester served
- rsp_result  out  3  held decode result
- rsp_hit  out  1  1 = code matched a case label; 0 = no-action
- miss_count  out  CNTW  saturating count of no-action decodes

## Operation
- States: IDLE, DECODE, RESP. Reset state IDLE.
- IDLE: if any req bit high at a clock edge, select winner round-robin, latch its val1/val2 and index, go to DECODE. Else stay.
- Round-robin: search starts at index ptr, wraps modulo NREQ; after granting i, ptr <= (i+1) mod NREQ (NREQ-1 wraps to 0). Reset ptr = 0.
- DECODE: gnt[winner] high this cycle only. masked = val1 & val2 (3 bits). Case: 3'b000 -> result 0; 3'b001 -> 1; 3'b010 -> 2; hit=1. Any other masked value: result register NOT written (keeps previous value), hit=0, miss_count increments, saturating at all-ones. Go to RESP at next edge.
- RESP: rsp_valid=1; rsp_id, rsp_result, rsp_hit stable. At edge with rsp_ready=1 -> IDLE. rsp_ready=0 holds RESP indefinitely; req ignored, no gnt.
- req is not sampled outside IDLE; a requester that keeps req high after its gnt is re-arbitrated on the next IDLE cycle.
- Held result register survives across transactions and requesters; it is shared state, not per requester.

## Timing
- Reset (asynchronous, any state): state IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_hit=0, miss_count=0, ptr=0. Reset mid-transaction discards the transaction; no response is issued.
- Capture edge E0 (IDLE, req nonzero) -> gnt high in cycle after E0 -> E1 writes result/hit/count -> rsp_valid high from E1 -> earliest release at E2 with rsp_ready=1 -> IDLE after E2.
- Minimum 3 cycles per transaction; next capture no earlier than E3.
- rsp_result/rsp_hit/rsp_id are registered outputs; never change while rsp_valid=1.
- All requesters high continuously: grant order 0,1,...,NREQ-1,0,...
- Operand changes after E0 do not affect the in-flight decode.

## Test plan
- Reset: assert rst_n=0 mid-RESP -> all outputs 0 immediately (no clock needed), state IDLE, next response has rsp_id from fresh ptr=0 arbitration.
- req[0]=1, val1=000, val2=000 -> gnt=01 for one cycle, then rsp_valid=1, rsp_id=0, rsp_result=0, rsp_hit=1, miss_count=0.
- req[1]=1, val1=001, val2=011 -> rsp_id=1, rsp_result=1, rsp_hit=1.
- Then req[0]=1, val1=111, val2=011 (masked 011) -> rsp_result=1 (held), rsp_hit=0, miss_count=1; then 110&110 -> rsp_result still 1, miss_count=2; then 010&010 -> rsp_result=2, hit=1.
- req=11 held with rsp_ready=1 -> gnt sequence 01,10,01,10 every 3 cycles; rsp_id 0,1,0,1.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and fields stable, gnt stays 0; 300 misses with CNTW=8 -> miss_count stops at 255.
